sync_debounce: RTL and testbench
================================

// Module: sync_debounce
// PURPOSE
//   Input conditioning stage feeding the d input of downstream sync-reset registers.
//   Takes an asynchronous, bouncy level (button, strap, external flag) and synchronises it to clk.
//   Filters glitches shorter than DB_CYCLES clocks.
//   Presents a clean registered level (plus optional edge pulses) to the next register stage.
// PARAMETERS
//   SYNC_STAGES  2    synchroniser flop count; legal >= 2
//   DB_CYCLES    16   consecutive differing samples required to accept a new level; legal >= 1
//   RST_VAL      1'b0 value of synchroniser chain and dout during/after reset
// PORTS
//   clk     in   1  clock
//   rst     in   1  reset, synchronous, active-high
//   din     in   1  asynchronous raw input level
//   dout    out  1  debounced, synchronised level (registered)
//   stable  out  1  1 = no level change pending (FSM in STABLE)
//   rise    out  1  1-cycle pulse, dout 0->1 (only with SYNC_DEBOUNCE_EDGE_EN)
//   fall    out  1  1-cycle pulse, dout 1->0 (only with SYNC_DEBOUNCE_EDGE_EN)
// BEHAVIOUR
//   Reset: clk is the only clock and rst is sampled only on posedge clk.
//     While rst=1 at an edge: sync chain=RST_VAL, dout=RST_VAL, cnt=0, state=STABLE, stable=1, rise=fall=0.
//     rst has priority over all other activity, including a count in progress (count discarded).
//   Synchroniser: sync[0]<=din; sync[i]<=sync[i-1]; s_sync=sync[SYNC_STAGES-1].
//     No logic between synchroniser flops.
//   Counter: cnt width $clog2(DB_CYCLES+1); never exceeds DB_CYCLES-1; no wrap.
//   FSM, 2 states:
//     STABLE:   s_sync==dout -> stay, cnt=0.
//               s_sync!=dout -> COUNT, cnt<=1.
//     COUNT:    s_sync==dout -> STABLE, cnt<=0 (glitch rejected, dout unchanged).
//               s_sync!=dout, cnt<DB_CYCLES-1 -> cnt<=cnt+1.
//               s_sync!=dout, cnt==DB_CYCLES-1 -> dout<=s_sync, cnt<=0, STABLE.
//   DB_CYCLES=1: a change is accepted on the first differing edge. COUNT is never held.
//   Accept rule: dout takes the new level on the DB_CYCLES-th consecutive edge with s_sync!=dout.
//   Latency: din settled before edge 0 -> dout updated after edge SYNC_STAGES+DB_CYCLES-1,
//     i.e. SYNC_STAGES+DB_CYCLES edges total.
//   stable = registered, 1 exactly when the next-state is STABLE; 0 throughout COUNT.
//   Pulses shorter than DB_CYCLES samples (after sync) never reach dout.
//   Toggling every cycle never reaches dout.
//   Output is glitch-free: dout driven directly from a flop.
// CONFIGURATION
//   SYNC_DEBOUNCE_EDGE_EN defined:
//     rise/fall ports exist, registered.
//     Asserted for exactly one cycle, in the same cycle dout first shows its new value.
//     Never both high. 0 in reset.
//   SYNC_DEBOUNCE_EDGE_EN undefined: rise/fall ports and their logic are absent.
//     dout/stable timing is identical either way.
// TESTING (SYNC_STAGES=2, DB_CYCLES=4, RST_VAL=0 unless noted)
//   1. rst=1 for 3 edges, din=1 -> dout=0, stable=1, rise=fall=0 throughout.
//      Then release rst with din=1 -> dout=1 after 6th edge.
//   2. din 0->1 before edge 0, held -> stable=0 from edge 2.
//      dout=1 and rise=1 for one cycle after edge 5.
//      stable=1 after edge 5.
//   3. din=1 for 3 cycles then 0 -> dout stays 0, rise never asserted.
//      stable returns to 1 once s_sync==dout.
//   4. din toggles every cycle for 50 cycles -> dout constant 0, no rise/fall.
//   5. din 0->1, rst=1 asserted at edge 4 (mid-count) -> dout=0, cnt=0, stable=1 at edge 4.
//      After release, din still 1: dout=1 SYNC_STAGES+DB_CYCLES edges later.
//   6. DB_CYCLES=1: din 1->0 after dout=1 -> dout=0 and fall=1 after edge 2.
//      Repeat with macro undefined -> same dout timing, ports absent (compile check).

Source files
------------

// File: rtl/sync_debounce_if.sv
// Level-signal bundle between a raw asynchronous source and the debouncer.
// rise/fall exist only when SYNC_DEBOUNCE_EDGE_EN is defined.
interface sync_debounce_if;
  // No valid/ready handshake here: din is a free-running level sampled every clock,
  // and dout/stable (plus rise/fall) are registered levels/pulses valid every cycle.
  logic din;
  logic dout;
  logic stable;
`ifdef SYNC_DEBOUNCE_EDGE_EN
  logic rise;
  logic fall;

  modport master (output din, input dout, input stable, input rise, input fall);
  modport slave  (input din, output dout, output stable, output rise, output fall);
`else
  modport master (output din, input dout, input stable);
  modport slave  (input din, output dout, output stable);
`endif
endinterface

// File: rtl/sync_debounce.sv
// Synchronise and debounce an asynchronous level; optional rise/fall pulses when
// SYNC_DEBOUNCE_EDGE_EN is defined. FSM state and counter exported for debug.
module sync_debounce #(
  parameter int   SYNC_STAGES = 2,
  parameter int   DB_CYCLES   = 16,
  parameter logic RST_VAL     = 1'b0,
  localparam int  CW          = $clog2(DB_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  sync_debounce_if.slave      db,
  output logic                dbg_state_o,
  output logic [CW-1:0]       dbg_cnt_o
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   dout_q;
  logic                   stable_q;
  logic                   s_sync;
  logic                   differ;
  logic                   accept;

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign differ = (s_sync != dout_q);
  // A change is taken on the DB_CYCLES-th consecutive differing edge; with
  // DB_CYCLES=1 that is the very first one, straight out of STABLE.
  assign accept = differ && ((state_q == ST_COUNT) ? (cnt_q == CW'(DB_CYCLES - 1))
                                                   : (DB_CYCLES == 1));

`ifdef SYNC_DEBOUNCE_EDGE_EN
  logic rise_q;
  logic fall_q;
  assign db.rise = rise_q;
  assign db.fall = fall_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= {SYNC_STAGES{RST_VAL}};
      dout_q   <= RST_VAL;
      cnt_q    <= '0;
      state_q  <= ST_STABLE;
      stable_q <= 1'b1;
`ifdef SYNC_DEBOUNCE_EDGE_EN
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], db.din};
`ifdef SYNC_DEBOUNCE_EDGE_EN
      rise_q <= 1'b0;
      fall_q <= 1'b0;
`endif
      if (accept) begin
        dout_q   <= s_sync;
        cnt_q    <= '0;
        state_q  <= ST_STABLE;
        stable_q <= 1'b1;
`ifdef SYNC_DEBOUNCE_EDGE_EN
        rise_q   <= s_sync;
        fall_q   <= ~s_sync;
`endif
      end else if (!differ) begin
        cnt_q    <= '0;
        state_q  <= ST_STABLE;
        stable_q <= 1'b1;
      end else if (state_q == ST_STABLE) begin
        cnt_q    <= CW'(1);
        state_q  <= ST_COUNT;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_q + CW'(1);
        stable_q <= 1'b0;
      end
    end
  end

  assign db.dout     = dout_q;
  assign db.stable   = stable_q;
  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: directed scenarios plus randomized levels checked
// against a run-length reference model (DB_CYCLES=4 and DB_CYCLES=1 instances).
module tb_sync_debounce;
  localparam int SS   = 2;
  localparam int DB_A = 4;
  localparam int DB_B = 1;

  logic clk;
  logic rst;
  logic st_a, st_b;
  logic [$clog2(DB_A+1)-1:0] cnt_a;
  logic [$clog2(DB_B+1)-1:0] cnt_b;
  int checks = 0;
  int errors = 0;

  sync_debounce_if bus_a ();
  sync_debounce_if bus_b ();

  sync_debounce #(.SYNC_STAGES(SS), .DB_CYCLES(DB_A), .RST_VAL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .db(bus_a), .dbg_state_o(st_a), .dbg_cnt_o(cnt_a));
  sync_debounce #(.SYNC_STAGES(SS), .DB_CYCLES(DB_B), .RST_VAL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .db(bus_b), .dbg_state_o(st_b), .dbg_cnt_o(cnt_b));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the level seen by the filter at an edge is din from SS edges
  // earlier; dout flips once that level has differed from dout for DB edges in a row.
  logic hist_a[$];
  logic hist_b[$];
  logic sa, sb;
  logic ma_dout, ma_rise, ma_fall, mb_dout, mb_rise, mb_fall;
  int   ma_run, mb_run;

  always @(posedge clk) begin
    if (rst) begin
      hist_a.delete(); ma_dout = 1'b0; ma_run = 0; ma_rise = 1'b0; ma_fall = 1'b0;
      hist_b.delete(); mb_dout = 1'b0; mb_run = 0; mb_rise = 1'b0; mb_fall = 1'b0;
    end else begin
      hist_a.push_back(bus_a.din);
      hist_b.push_back(bus_b.din);
      sa = (hist_a.size() > SS) ? hist_a[hist_a.size()-1-SS] : 1'b0;
      sb = (hist_b.size() > SS) ? hist_b[hist_b.size()-1-SS] : 1'b0;
      ma_rise = 1'b0; ma_fall = 1'b0; mb_rise = 1'b0; mb_fall = 1'b0;
      ma_run = (sa != ma_dout) ? ma_run + 1 : 0;
      if (ma_run == DB_A) begin
        ma_dout = sa; ma_run = 0; ma_rise = sa; ma_fall = ~sa;
      end
      mb_run = (sb != mb_dout) ? mb_run + 1 : 0;
      if (mb_run == DB_B) begin
        mb_dout = sb; mb_run = 0; mb_rise = sb; mb_fall = ~sb;
      end
      if (hist_a.size() > 8) void'(hist_a.pop_front());
      if (hist_b.size() > 8) void'(hist_b.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.din = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus_a.dout !== 1'b0 || bus_a.stable !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold[%0d]: dout=%b stable=%b want dout=0 stable=1", i, bus_a.dout, bus_a.stable);
      end
`ifdef SYNC_DEBOUNCE_EDGE_EN
      checks++;
      if (bus_a.rise !== 1'b0 || bus_a.fall !== 1'b0) begin
        errors++;
        $display("FAIL reset_edges[%0d]: rise=%b fall=%b want 0 0", i, bus_a.rise, bus_a.fall);
      end
`endif
    end
    rst = 1'b0;
    for (int e = 0; e < 6; e++) begin
      tick();
      checks++;
      if (bus_a.dout !== (e == 5)) begin
        errors++;
        $display("FAIL reset_release edge %0d: dout=%b want %b", e, bus_a.dout, (e == 5));
      end
    end
  endtask

  task automatic test_rise();
    bus_a.din = 1'b0;
    repeat (10) tick();
    bus_a.din = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (bus_a.stable !== !(e >= 2 && e <= 4) || bus_a.dout !== (e >= 5)) begin
        errors++;
        $display("FAIL rise_timing edge %0d: stable=%b dout=%b want stable=%b dout=%b",
                 e, bus_a.stable, bus_a.dout, !(e >= 2 && e <= 4), (e >= 5));
      end
`ifdef SYNC_DEBOUNCE_EDGE_EN
      checks++;
      if (bus_a.rise !== (e == 5) || bus_a.fall !== 1'b0) begin
        errors++;
        $display("FAIL rise_pulse edge %0d: rise=%b fall=%b want rise=%b fall=0", e, bus_a.rise, bus_a.fall, (e == 5));
      end
`endif
    end
  endtask

  task automatic test_glitch();
    bus_a.din = 1'b0;
    repeat (10) tick();
    bus_a.din = 1'b1;
    for (int e = 0; e < 16; e++) begin
      if (e == 3) bus_a.din = 1'b0;
      tick();
      checks++;
      if (bus_a.dout !== 1'b0) begin
        errors++;
        $display("FAIL glitch_dout edge %0d: dout=%b want 0", e, bus_a.dout);
      end
`ifdef SYNC_DEBOUNCE_EDGE_EN
      checks++;
      if (bus_a.rise !== 1'b0) begin
        errors++;
        $display("FAIL glitch_rise edge %0d: rise=%b want 0", e, bus_a.rise);
      end
`endif
    end
    checks++;
    if (bus_a.stable !== 1'b1) begin
      errors++;
      $display("FAIL glitch_stable: stable=%b want 1", bus_a.stable);
    end
  endtask

  task automatic test_toggle();
    for (int e = 0; e < 50; e++) begin
      bus_a.din = e[0];
      tick();
      checks++;
      if (bus_a.dout !== 1'b0) begin
        errors++;
        $display("FAIL toggle_dout cycle %0d: dout=%b want 0", e, bus_a.dout);
      end
`ifdef SYNC_DEBOUNCE_EDGE_EN
      checks++;
      if (bus_a.rise !== 1'b0 || bus_a.fall !== 1'b0) begin
        errors++;
        $display("FAIL toggle_edges cycle %0d: rise=%b fall=%b want 0 0", e, bus_a.rise, bus_a.fall);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    bus_a.din = 1'b0;
    repeat (10) tick();
    bus_a.din = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus_a.dout !== 1'b0 || cnt_a !== '0 || bus_a.stable !== 1'b1 || st_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: dout=%b cnt=%0d stable=%b state=%b want 0 0 1 0",
               bus_a.dout, cnt_a, bus_a.stable, st_a);
    end
    rst = 1'b0;
    for (int e = 0; e < SS + DB_A + 1; e++) begin
      tick();
      checks++;
      if (bus_a.dout !== (e >= SS + DB_A - 1)) begin
        errors++;
        $display("FAIL reset_mid_release edge %0d: dout=%b want %b", e, bus_a.dout, (e >= SS + DB_A - 1));
      end
    end
  endtask

  task automatic test_db1();
    bus_b.din = 1'b1;
    repeat (5) tick();
    checks++;
    if (bus_b.dout !== 1'b1) begin
      errors++;
      $display("FAIL db1_setup: dout=%b want 1", bus_b.dout);
    end
    bus_b.din = 1'b0;
    for (int e = 0; e < 4; e++) begin
      tick();
      checks++;
      if (bus_b.dout !== (e < 2) || bus_b.stable !== 1'b1) begin
        errors++;
        $display("FAIL db1_fall edge %0d: dout=%b stable=%b want dout=%b stable=1", e, bus_b.dout, bus_b.stable, (e < 2));
      end
`ifdef SYNC_DEBOUNCE_EDGE_EN
      checks++;
      if (bus_b.fall !== (e == 2) || bus_b.rise !== 1'b0) begin
        errors++;
        $display("FAIL db1_pulse edge %0d: fall=%b rise=%b want fall=%b rise=0", e, bus_b.fall, bus_b.rise, (e == 2));
      end
`endif
    end
  endtask

  task automatic test_random();
    int hold_a = 0;
    int hold_b = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_a == 0) begin bus_a.din = 1'($urandom_range(0, 1)); hold_a = $urandom_range(1, 7); end
      if (hold_b == 0) begin bus_b.din = 1'($urandom_range(0, 1)); hold_b = $urandom_range(1, 3); end
      hold_a--; hold_b--;
      rst = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if (bus_a.dout !== ma_dout || bus_a.stable !== (ma_run == 0) ||
          bus_b.dout !== mb_dout || bus_b.stable !== (mb_run == 0)) begin
        errors++;
        $display("FAIL random cycle %0d: a dout=%b stable=%b b dout=%b stable=%b want a %b %b b %b %b",
                 c, bus_a.dout, bus_a.stable, bus_b.dout, bus_b.stable,
                 ma_dout, (ma_run == 0), mb_dout, (mb_run == 0));
      end
`ifdef SYNC_DEBOUNCE_EDGE_EN
      checks++;
      if (bus_a.rise !== ma_rise || bus_a.fall !== ma_fall ||
          bus_b.rise !== mb_rise || bus_b.fall !== mb_fall) begin
        errors++;
        $display("FAIL random_edges cycle %0d: a rise=%b fall=%b b rise=%b fall=%b want a %b %b b %b %b",
                 c, bus_a.rise, bus_a.fall, bus_b.rise, bus_b.fall, ma_rise, ma_fall, mb_rise, mb_fall);
      end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_a.din = 1'b0;
    bus_b.din = 1'b0;
    @(negedge clk);
    test_reset();
    test_rise();
    test_glitch();
    test_toggle();
    test_reset_mid();
    test_db1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
